// File: rtl/psum_accumulator.sv
// Shift-accumulates per-column psums over a configurable number of passes and
// presents the finished row on valid/ready. Optional macro ACC_RELU_EN clamps negative lanes to 0.
module psum_accumulator #(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned PSUM_W     = 32,
    parameter int unsigned ACC_W      = 40,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT_W-1:0]             cfg_passes,
    input  logic [4:0]                   cfg_shift,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ARRAY_SIZE*PSUM_W-1:0] psums,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARRAY_SIZE*ACC_W-1:0]  out_data,
    output logic                         busy,
    output logic                         overflow
);

    localparam int unsigned EXT_W = ACC_W + 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       count_q, passes_q;
    logic [CNT_W-1:0]       passes_eff;
    logic [ACC_W-1:0]       acc_q  [ARRAY_SIZE];
    logic [ACC_W-1:0]       term_c [ARRAY_SIZE];
    logic [ACC_W-1:0]       sum_c  [ARRAY_SIZE];
    logic [ARRAY_SIZE-1:0]  shift_ovf, add_ovf;
    logic                   in_ready_q, out_valid_q, busy_q, overflow_q;

    assign passes_eff = (cfg_passes == '0) ? CNT_W'(1) : cfg_passes;

    // Per-lane term formation, shift-loss detection and wrapping add
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] shifted;

        assign ext     = EXT_W'($signed(psums[i*PSUM_W +: PSUM_W]));
        assign shifted = ext <<< cfg_shift;
        assign term_c[i] = shifted[ACC_W-1:0];
        // Discarded high bits must all match the kept sign bit
        assign shift_ovf[i] = ~((&shifted[EXT_W-1:ACC_W-1]) | ~(|shifted[EXT_W-1:ACC_W-1]));
        assign sum_c[i]   = acc_q[i] + term_c[i];
        assign add_ovf[i] = (acc_q[i][ACC_W-1] == term_c[i][ACC_W-1]) &&
                            (sum_c[i][ACC_W-1] != acc_q[i][ACC_W-1]);

`ifdef ACC_RELU_EN
        assign out_data[i*ACC_W +: ACC_W] = acc_q[i][ACC_W-1] ? '0 : acc_q[i];
`else
        assign out_data[i*ACC_W +: ACC_W] = acc_q[i];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = (passes_eff == CNT_W'(1)) ? S_DRAIN : S_ACCUM;
            end
            S_ACCUM: begin
                if (in_valid && (count_q + CNT_W'(1) == passes_q)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulators, counters, sticky overflow and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARRAY_SIZE; i++) acc_q[i] <= '0;
            count_q     <= '0;
            passes_q    <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < ARRAY_SIZE; i++) acc_q[i] <= term_c[i];
                        count_q    <= CNT_W'(1);
                        passes_q   <= passes_eff;
                        overflow_q <= |shift_ovf;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        for (int i = 0; i < ARRAY_SIZE; i++) acc_q[i] <= sum_c[i];
                        count_q    <= count_q + CNT_W'(1);
                        overflow_q <= overflow_q | (|shift_ovf) | (|add_ovf);
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        for (int i = 0; i < ARRAY_SIZE; i++) acc_q[i] <= '0;
                        count_q <= '0;
                    end
                end
                default: ;
            endcase
            in_ready_q  <= (state_d != S_DRAIN);
            out_valid_q <= (state_d == S_DRAIN);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized plus directed bench for psum_accumulator against an arithmetic reference model.
// Build with or without ACC_RELU_EN; the model follows the same macro.
module tb_psum_accumulator;

    localparam int unsigned ARRAY_SIZE = 8;
    localparam int unsigned PSUM_W     = 32;
    localparam int unsigned ACC_W      = 40;
    localparam int unsigned CNT_W      = 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [CNT_W-1:0]             cfg_passes;
    logic [4:0]                   cfg_shift;
    logic                         in_valid;
    logic                         in_ready;
    logic [ARRAY_SIZE*PSUM_W-1:0] psums;
    logic                         out_valid;
    logic                         out_ready;
    logic [ARRAY_SIZE*ACC_W-1:0]  out_data;
    logic                         busy;
    logic                         overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: true arithmetic lanes, wrapped to ACC_W
    longint macc [ARRAY_SIZE];
    bit     movf;
    int     mcnt, mpasses;

    psum_accumulator #(
        .ARRAY_SIZE(ARRAY_SIZE), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_passes(cfg_passes), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_ready(in_ready), .psums(psums),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    function automatic longint wrap(input longint v);
        longint r;
        r = v <<< (64 - ACC_W);
        return r >>> (64 - ACC_W);
    endfunction

    function automatic logic [ARRAY_SIZE*PSUM_W-1:0] fill(input int v);
        logic [ARRAY_SIZE*PSUM_W-1:0] p;
        for (int i = 0; i < ARRAY_SIZE; i++) p[i*PSUM_W +: PSUM_W] = PSUM_W'(v);
        return p;
    endfunction

    task automatic model_beat(input logic [ARRAY_SIZE*PSUM_W-1:0] p, input int sh, input int np);
        if (mcnt == 0) begin
            mpasses = (np == 0) ? 1 : np;
            movf    = 1'b0;
        end
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            longint ps, t, tw, s;
            ps = longint'($signed(p[i*PSUM_W +: PSUM_W]));
            t  = ps * (longint'(1) <<< sh);
            tw = wrap(t);
            if (tw != t) movf = 1'b1;
            if (mcnt == 0) macc[i] = tw;
            else begin
                s = macc[i] + tw;
                if (wrap(s) != s) movf = 1'b1;
                macc[i] = wrap(s);
            end
        end
        mcnt++;
    endtask

    // Offer one beat at a negedge, hold until accepted, return at the following negedge
    task automatic beat(input logic [ARRAY_SIZE*PSUM_W-1:0] p, input int sh, input int np);
        int n;
        in_valid   = 1'b1;
        psums      = p;
        cfg_shift  = 5'(sh);
        cfg_passes = CNT_W'(np);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("beat_accept_timeout", 64'(in_ready), 64'(1));
        model_beat(p, sh, np);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int stall);
        logic [ACC_W-1:0] e [ARRAY_SIZE];
        logic [ARRAY_SIZE*ACC_W-1:0] held;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            longint v;
            v = macc[i];
`ifdef ACC_RELU_EN
            if (v < 0) v = 0;
`endif
            e[i] = ACC_W'(v);
        end
        check({tag, "_out_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_in_ready_drain"}, 64'(in_ready), 64'(0));
        for (int i = 0; i < ARRAY_SIZE; i++)
            check($sformatf("%s_lane%0d", tag, i), 64'(out_data[i*ACC_W +: ACC_W]), 64'(e[i]));
        check({tag, "_overflow"}, 64'(overflow), 64'(movf));
        held = out_data;
        for (int c = 0; c < stall; c++) begin
            in_valid = 1'b1;
            psums    = fill(int'($urandom));
            @(negedge clk);
            check({tag, "_stall_ready"}, 64'(in_ready), 64'(0));
            check({tag, "_stall_valid"}, 64'(out_valid), 64'(1));
            check({tag, "_stall_stable"}, 64'(held == out_data), 64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_post_busy"}, 64'(busy), 64'(0));
        check({tag, "_post_overflow"}, 64'(overflow), 64'(movf));
        mcnt = 0;
    endtask

    initial begin
        logic [ARRAY_SIZE*PSUM_W-1:0] p;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_passes = '0; cfg_shift = '0; psums = '0;
        mcnt = 0; movf = 1'b0; mpasses = 1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_out_data", 64'(out_data == '0), 64'(1));
        rst = 1'b1;
        @(negedge clk);

        // Single pass, lane 3 negative
        p = fill(5);
        p[3*PSUM_W +: PSUM_W] = PSUM_W'(-7);
        beat(p, 0, 1);
        expect_result("single", 0);

        // Two-pass bit fusion: 3 + (2 << 4)
        beat(fill(3), 0, 2);
        check("fuse_early_valid", 64'(out_valid), 64'(0));
        check("fuse_busy", 64'(busy), 64'(1));
        beat(fill(2), 4, 2);
        check("fuse_lane0_35", 64'(out_data[ACC_W-1:0]), 64'(35));
        expect_result("fuse", 0);

        // Backpressure, then a fresh load must not include the old value
        beat(fill(9), 0, 1);
        expect_result("bp", 5);
        beat(fill(1), 0, 1);
        expect_result("bp_next", 0);

        // Signed add overflow, then cleared by the next result's first beat
        beat(fill(32'h7FFF_FFFF), 8, 2);
        beat(fill(32'h7FFF_FFFF), 8, 2);
        check("ovf_set", 64'(overflow), 64'(1));
        expect_result("ovf", 0);
        beat(fill(1), 0, 1);
        check("ovf_cleared", 64'(overflow), 64'(0));
        expect_result("ovf_next", 0);

        // Asynchronous reset mid-accumulation
        beat(fill(100), 0, 4);
        beat(fill(100), 0, 4);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_out_data", 64'(out_data == '0), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        mcnt = 0;
        @(negedge clk);
        beat(fill(6), 0, 1);
        check("arst_fresh_lane0", 64'(out_data[ACC_W-1:0]), 64'(6));
        expect_result("arst_fresh", 0);

        // Zero passes behaves as one; negative result exercises the clamp
        beat(fill(-4), 0, 0);
        expect_result("zero_pass", 0);

        // Randomized results; cfg_passes on later beats is noise that must be ignored
        for (int r = 0; r < 40; r++) begin
            int np, n;
            np = int'($urandom_range(0, 4));
            n  = (np == 0) ? 1 : np;
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < ARRAY_SIZE; i++) begin
                    logic [31:0] v;
                    v = $urandom;
                    if ($urandom_range(0, 1) == 1) v = 32'($signed(v) >>> 18);
                    p[i*PSUM_W +: PSUM_W] = v;
                end
                beat(p, int'($urandom_range(0, 31)), (b == 0) ? np : int'($urandom_range(0, 255)));
                if (b < n - 1) check("rand_early_valid", 64'(out_valid), 64'(0));
            end
            expect_result("rand", int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
Downstream of systolic_array; consumes its per-column psums vector. Shift-accumulates psums over a configurable number of passes, so partial products from low-precision (Bit Fusion style) passes combine into full-precision results. Presents the finished row on a valid/ready output to the output buffer.

Parameters:
ARRAY_SIZE, 8, number of columns/lanes; matches systolic_array.
PSUM_W, 32, width of each incoming signed psum.
ACC_W, 40, width of each signed accumulator lane; ACC_W must be at least PSUM_W.
CNT_W, 8, width of the pass counter and cfg_passes.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
cfg_passes  input  CNT_W  passes per result; sampled on the first accepted beat; 0 treated as 1
cfg_shift  input  5  left-shift for the current beat's psums; sampled with every accepted beat
in_valid  input  1  psums beat valid
in_ready  output  1  accumulator can accept a beat
psums  input  ARRAY_SIZE*PSUM_W  packed signed psums; lane i = bits [i*PSUM_W +: PSUM_W]
out_valid  output  1  result row valid
out_ready  input  1  downstream accepts the row
out_data  output  ARRAY_SIZE*ACC_W  packed signed results; lane i = bits [i*ACC_W +: ACC_W]
busy  output  1  FSM not in IDLE
overflow  output  1  sticky; some lane wrapped during the current result

Behaviour:
- Reset (rst=0, async): state=IDLE, all accumulators=0, pass count=0, in_ready=1, out_valid=0, out_data=0, busy=0, overflow=0.
- Beat accept: in_valid & in_ready on a rising edge.
- Lane term: psum lane sign-extended to ACC_W, then arithmetic left-shifted by cfg_shift. Bits shifted past ACC_W are lost; this sets overflow if they differ from the result's sign bit.
- IDLE:
  - in_ready=1.
  - On accept: acc = term (load, not add); count=1; latch passes = max(cfg_passes, 1); clear overflow, then apply this beat's overflow.
  - If passes==1: go to DRAIN, else go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: acc = acc + term, wrapping at ACC_W; count += 1.
  - Signed add overflow on any lane (operand signs equal, result sign differs) sets overflow.
  - When the post-increment count equals passes: go to DRAIN.
  - No accept: hold state.
- DRAIN:
  - in_ready=0; out_valid=1.
  - out_data is driven from the accumulators and held stable until accepted.
  - On out_ready: go to IDLE, clear accumulators and count, out_valid=0 next cycle.
  - overflow holds its value until the next result's first beat.
- Latency: out_valid rises on the clock edge after the final beat is accepted (1 cycle). A 1-pass result still takes 1 cycle to reach DRAIN.
- Throughput: one result per passes+1 cycles at best. There is no DRAIN/IDLE overlap: a beat offered during DRAIN waits, because in_ready=0.
- Changes to cfg_passes mid-result are ignored. cfg_shift may change every beat.
- busy=1 in ACCUM and DRAIN.
- in_ready is a function of state only; it never depends combinationally on in_valid. out_valid is registered.
- Reset mid-ACCUM or mid-DRAIN: an immediate async clear to the reset values; the partial result is discarded.
- ARRAY_SIZE lanes update in parallel; no inter-lane dependency.

Optional Feature:
ACC_RELU_EN
- Defined: each out_data lane whose accumulator is negative is driven as 0. The clamp is combinational on the output only; the accumulator is unchanged and overflow is unaffected.
- Undefined: out_data is the raw signed accumulator.

Test Plan:
- Single pass, cfg_passes=1, cfg_shift=0, all lanes psum=5 (lane 3 = -7) -> out_valid 1 cycle after accept; lanes = 5, lane 3 = -7 (40-bit sign-extended); overflow=0.
- Bit-fusion 2 passes, cfg_passes=2: beat1 shift=0 psum=3, beat2 shift=4 psum=2 -> every lane = 3 + 32 = 35; in_ready=0 while out_valid is held.
- Backpressure: out_ready=0 for 5 cycles in DRAIN, in_valid held high -> out_data stable, no beat accepted; out_ready=1 -> IDLE next cycle, next beat loads without summing the old value.
- Overflow: cfg_passes=2, shift=8, psum=0x7FFFFFFF twice -> each lane wraps; overflow=1 in DRAIN; overflow clears on the next result's first beat.
- Reset mid-ACCUM: after 2 of 4 beats, pulse rst low asynchronously -> all outputs at reset values immediately; a fresh 1-pass run returns the new beat only.
- cfg_passes=0 with ACC_RELU_EN: psum=-4 -> treated as 1 pass; lane output 0; without the macro, output -4.
